// File: rtl/execute_mc.sv
// execute_mc: execute stage, one-cycle ALU plus iterative RISC-V M-extension unit.
// Define UCRV_MULDIV_EN to build the multiply/divide datapath.
package execute_mc_pkg;
  typedef enum logic [3:0] {
    EX_ADD, EX_SUB, EX_SLL, EX_SLT, EX_SLTU, EX_XOR,
    EX_SRL, EX_SRA, EX_OR, EX_AND, EX_PASSB
  } ex_func;
  typedef enum logic {RS1_PC = 1'b0, RS1_REG = 1'b1} rs1_sel;
  typedef enum logic {RS2_IMM = 1'b0, RS2_REG = 1'b1} rs2_sel;
endpackage

module execute_mc
  import execute_mc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk_i,
  input  logic              n_rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              flush_i,
  input  ex_func            ex_func_i,
  input  logic              md_en_i,
  input  logic [2:0]        md_op_i,
  input  rs1_sel            rs1_sel_i,
  input  rs2_sel            rs2_sel_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   immediate_i,
  input  logic [4:0]        rd_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic              zero_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   pc_4_o,
  output logic [XLEN-1:0]   pc_imm_o,
  output logic [4:0]        rd_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              illegal_o
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]   result_q, pc_q, pc4_q, pcimm_q;
  logic [4:0]        rd_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              illegal_q;

  logic [XLEN-1:0] op_a, op_b, alu_res, md_res;
  logic            accept, go_busy, md_done;

  assign op_a = (rs1_sel_i == RS1_REG) ? rs1_data_i : pc_i;
  assign op_b = (rs2_sel_i == RS2_REG) ? rs2_data_i : immediate_i;

  assign in_ready_o = (state_q == S_IDLE) ||
                      ((state_q == S_DONE) && out_ready_i);
  assign accept     = in_valid_i && in_ready_o && !flush_i;

`ifdef UCRV_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  assign go_busy = md_en_i && MD_EN;

  always_comb begin
    alu_res = '0;
    unique case (ex_func_i)
      EX_ADD:   alu_res = op_a + op_b;
      EX_SUB:   alu_res = op_a - op_b;
      EX_SLL:   alu_res = op_a << op_b[SW-1:0];
      EX_SLT:   alu_res = {{(XLEN-1){1'b0}},
                           $signed(op_a) < $signed(op_b)};
      EX_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      EX_XOR:   alu_res = op_a ^ op_b;
      EX_SRL:   alu_res = op_a >> op_b[SW-1:0];
      EX_SRA:   alu_res = $unsigned($signed(op_a) >>> op_b[SW-1:0]);
      EX_OR:    alu_res = op_a | op_b;
      EX_AND:   alu_res = op_a & op_b;
      EX_PASSB: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

`ifdef UCRV_MULDIV_EN
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(XLEN);

  logic [XLEN-1:0] hi_q, lo_q, opb_q, a_q;
  logic [2:0]      op_q;
  logic            neg_q, bzero_q;
  logic [CW-1:0]   cnt_q;

  logic            sa, sb, a_neg, b_neg, div_ge;
  logic [XLEN-1:0] a_mag, b_mag, div_sub, quo, rem;
  logic [XLEN:0]   mul_sum, div_r;
  logic [2*XLEN-1:0] prod;

  assign sa = (md_op_i == 3'd1) || (md_op_i == 3'd2) ||
              (md_op_i == 3'd4) || (md_op_i == 3'd6);
  assign sb = (md_op_i == 3'd1) || (md_op_i == 3'd4) ||
              (md_op_i == 3'd6);
  assign a_neg = sa && op_a[XLEN-1];
  assign b_neg = sb && op_b[XLEN-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  // Shift-add multiply: lo_q holds the multiplier, product forms in {hi_q, lo_q}.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  // Restoring divide: hi_q is the partial remainder, lo_q collects quotient bits.
  assign div_r   = {hi_q, lo_q[XLEN-1]};
  assign div_ge  = div_r >= {1'b0, opb_q};
  assign div_sub = div_r[XLEN-1:0] - opb_q;

  assign prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo  = bzero_q ? '1 : (neg_q ? -lo_q : lo_q);
  assign rem  = bzero_q ? a_q : (neg_q ? -hi_q : hi_q);

  always_comb begin
    md_res = '0;
    unique case (1'b1)
      op_q == 3'd0:                    md_res = prod[XLEN-1:0];
      !op_q[2] && op_q != 3'd0:        md_res = prod[2*XLEN-1:XLEN];
      op_q[2:1] == 2'b10:              md_res = quo;
      default:                         md_res = rem;
    endcase
  end

  assign md_done = (state_q == S_BUSY) && (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      a_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      bzero_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept && md_en_i) begin
      hi_q    <= '0;
      lo_q    <= a_mag;
      opb_q   <= b_mag;
      a_q     <= op_a;
      op_q    <= md_op_i;
      neg_q   <= (md_op_i[2] && md_op_i[1]) ? a_neg : (a_neg ^ b_neg);
      bzero_q <= (op_b == '0);
      cnt_q   <= '0;
    end else if ((state_q == S_BUSY) && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
      if (!op_q[2]) begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end else begin
        hi_q <= div_ge ? div_sub : div_r[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], div_ge};
      end
    end
  end
`else
  logic unused_md;
  assign unused_md = ^md_op_i;
  assign md_res    = '0;
  assign md_done   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = go_busy ? S_BUSY : S_DONE;
      S_BUSY: if (md_done) state_d = S_DONE;
      S_DONE: begin
        if (out_ready_i) begin
          if (accept) state_d = go_busy ? S_BUSY : S_DONE;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      pc_q      <= '0;
      pc4_q     <= '0;
      pcimm_q   <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        result_q  <= md_en_i ? '0 : alu_res;
        illegal_q <= md_en_i && !MD_EN;
        pc_q      <= pc_i;
        pc4_q     <= pc_i + XLEN'(4);
        pcimm_q   <= pc_i + immediate_i;
        rd_q      <= rd_i;
        ctrl_q    <= ctrl_i;
      end else if (md_done) begin
        result_q <= md_res;
      end
    end
  end

  assign out_valid_o = (state_q == S_DONE);
  assign result_o    = result_q;
  assign zero_o      = (result_q == '0);
  assign pc_o        = pc_q;
  assign pc_4_o      = pc4_q;
  assign pc_imm_o    = pcimm_q;
  assign rd_o        = rd_q;
  assign ctrl_o      = ctrl_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_execute_mc.sv
// tb_execute_mc: randomized scoreboard bench for execute_mc.
// Reference model applies the RISC-V ALU and M-extension rules with plain arithmetic.
`timescale 1ns/1ps
module tb_execute_mc;
  import execute_mc_pkg::*;

  localparam int XLEN = 32;
  localparam int CTRL_W = 16;
`ifdef UCRV_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int MD_LAT = MD ? XLEN + 1 : 1;

  typedef struct {
    logic [31:0] res;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pci;
    logic [4:0]  rd;
    logic [15:0] ctrl;
    logic        ill;
    int          acc;
    int          lat;
    bit          seen;
  } exp_t;

  exp_t q[$];

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic in_valid = 1'b0, in_ready, flush = 1'b0;
  ex_func func = EX_ADD;
  logic md_en = 1'b0;
  logic [2:0] md_op = '0;
  rs1_sel s1 = RS1_REG;
  rs2_sel s2 = RS2_REG;
  logic [31:0] pc = '0, r1 = '0, r2 = '0, imm = '0;
  logic [4:0] rd = '0;
  logic [15:0] ctrl = '0;
  logic out_valid, out_ready = 1'b0;
  logic [31:0] result, pc_o, pc_4, pc_imm;
  logic zero, illegal;
  logic [4:0] rd_o;
  logic [15:0] ctrl_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int xfers = 0;
  bit rand_mode = 1'b0;

  execute_mc #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk_i(clk), .n_rst(n_rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush),
    .ex_func_i(func), .md_en_i(md_en), .md_op_i(md_op),
    .rs1_sel_i(s1), .rs2_sel_i(s2),
    .pc_i(pc), .rs1_data_i(r1), .rs2_data_i(r2), .immediate_i(imm),
    .rd_i(rd), .ctrl_i(ctrl),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .zero_o(zero),
    .pc_o(pc_o), .pc_4_o(pc_4), .pc_imm_o(pc_imm),
    .rd_o(rd_o), .ctrl_o(ctrl_o), .illegal_o(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [31:0] ref_alu(input ex_func f,
      input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic signed [31:0] as;
    sh = b % 32;
    as = a;
    case (f)
      EX_ADD:   return a + b;
      EX_SUB:   return a - b;
      EX_SLL:   return a << sh;
      EX_SLT:   return (as < $signed(b)) ? 32'd1 : 32'd0;
      EX_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      EX_XOR:   return a ^ b;
      EX_SRL:   return a >> sh;
      EX_SRA:   return 32'(as >>> sh);
      EX_OR:    return a | b;
      EX_AND:   return a & b;
      EX_PASSB: return b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    bit ovf;
    sa = $signed(a);
    sb = $signed(b);
    ub = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input bit m, input logic [2:0] mop, input ex_func f,
      input bit u1, input bit u2, input logic [31:0] p, input logic [31:0] a1,
      input logic [31:0] a2, input logic [31:0] im, input logic [4:0] d,
      input logic [15:0] c);
    exp_t e;
    logic [31:0] a, b;
    bit ok;
    md_en = m; md_op = mop; func = f;
    s1 = u1 ? RS1_REG : RS1_PC;
    s2 = u2 ? RS2_REG : RS2_IMM;
    pc = p; r1 = a1; r2 = a2; imm = im; rd = d; ctrl = c;
    in_valid = 1'b1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!ok) begin
      fail("issue_timeout");
      in_valid = 1'b0;
      step(1);
      return;
    end
    a = u1 ? a1 : p;
    b = u2 ? a2 : im;
    e.res  = m ? (MD ? ref_md(mop, a, b) : 32'd0) : ref_alu(f, a, b);
    e.ill  = m && !MD;
    e.lat  = m ? MD_LAT : 1;
    e.acc  = cyc;
    e.pc   = p;
    e.pc4  = p + 32'd4;
    e.pci  = p + im;
    e.rd   = d;
    e.ctrl = c;
    e.seen = 1'b0;
    @(posedge clk); #1;
    q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) step(1);
    if (q.size() != 0) fail("drain_timeout");
  endtask

  task automatic check_reset_outputs();
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_pc", pc_o, 0);
    chk("rst_pc4", pc_4, 0);
    chk("rst_pcimm", pc_imm, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 16));
      default: return 32'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (n_rst) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          fail("unexpected_valid");
        end else begin
          if (!q[0].seen) begin
            chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
            q[0].seen = 1'b1;
          end
          chk("result", result, q[0].res);
          chk("zero", zero, q[0].res == 0);
          chk("pc", pc_o, q[0].pc);
          chk("pc4", pc_4, q[0].pc4);
          chk("pcimm", pc_imm, q[0].pci);
          chk("rd", rd_o, q[0].rd);
          chk("ctrl", ctrl_o, q[0].ctrl);
          chk("illegal", illegal, q[0].ill);
          chk("in_ready_done", in_ready, out_ready);
          if (out_ready) begin
            void'(q.pop_front());
            xfers++;
          end
        end
      end else begin
        chk("in_ready_idle_busy", in_ready, q.size() == 0);
      end
    end
  end

  initial begin
    int x0, c0, nv;
    step(3);
    @(negedge clk);
    check_reset_outputs();
    n_rst = 1'b1;
    step(1);

    out_ready = 1'b1;
    issue(0, 0, EX_ADD, 1, 1, 32'h100, 32'd5, 32'd7, 32'h20, 5'd3, 16'h1234);
    issue(1, 3'd4, EX_ADD, 1, 1, 32'h200, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h0, 5'd4, 16'h0004);
    issue(1, 3'd6, EX_ADD, 1, 1, 32'h204, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h0, 5'd5, 16'h0006);
    issue(1, 3'd5, EX_ADD, 1, 1, 32'h208, 32'd100, 32'd0, 32'h0, 5'd6, 16'h5);
    issue(1, 3'd7, EX_ADD, 1, 1, 32'h20c, 32'd100, 32'd0, 32'h0, 5'd7, 16'h7);
    issue(1, 3'd1, EX_ADD, 1, 1, 32'h210, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'h0, 5'd8, 16'h1);
    issue(1, 3'd3, EX_ADD, 1, 1, 32'h214, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'h0, 5'd9, 16'h3);
    issue(0, 0, EX_SUB, 0, 0, 32'h40, 32'd0, 32'd0, 32'h40, 5'd10, 16'hA);
    wait_drain();

    out_ready = 1'b0;
    issue(0, 0, EX_SUB, 1, 0, 32'h300, 32'd50, 32'd0, 32'd8, 5'd11, 16'hBEEF);
    for (int i = 0; i < 100 && !out_valid; i++) step(1);
    step(5);
    x0 = xfers;
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(2);
    chk("single_transfer", 64'(xfers - x0), 1);
    chk("valid_after_xfer", out_valid, 0);

    issue(1, 3'd0, EX_ADD, 1, 1, 32'h400, 32'd7, 32'd9, 32'h0, 5'd12, 16'hC);
    step(9);
    flush = 1'b1;
    in_valid = 1'b1; md_en = 1'b0; func = EX_ADD;
    step(1);
    flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_flush", in_ready, 1);
    nv = 0;
    for (int i = 0; i < XLEN + 5; i++) begin
      if (out_valid) nv++;
      @(negedge clk);
    end
    chk("no_valid_after_flush", 64'(nv), 0);
    step(1);

    out_ready = 1'b1;
    x0 = xfers;
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      issue(0, 0, ex_func'($urandom_range(0, 10)), 1, 1, 32'($urandom),
            32'($urandom), 32'($urandom), 32'($urandom), 5'(i), 16'(i));
    chk("b2b_cycles", 64'(cyc - c0), 8);
    step(2);
    chk("b2b_transfers", 64'(xfers - x0), 8);

    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++)
      issue($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
            ex_func'($urandom_range(0, 10)), 1'($urandom), 1'($urandom),
            rnd_val(), rnd_val(), rnd_val(), rnd_val(),
            5'($urandom), 16'($urandom));
    rand_mode = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    out_ready = 1'b0;
    issue(1, 3'd4, EX_ADD, 1, 1, 32'h500, 32'd1000, 32'd7, 32'h0, 5'd13, 16'hD);
    step(4);
    #2;
    n_rst = 1'b0;
    q.delete();
    #1;
    check_reset_outputs();
    @(negedge clk);
    n_rst = 1'b1;
    step(1);
    out_ready = 1'b1;
    issue(0, 0, EX_ADD, 1, 1, 32'h600, 32'd1, 32'd2, 32'h4, 5'd14, 16'hE);
    wait_drain();
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_mc.md
EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits (power of two, >= 8).
REQ-002 SHALL have parameter CTRL_W, default 16, width of the opaque control sideband carried to the memory stage.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid_i / in_ready_o, input / output, 1 each, issue handshake from decode.
REQ-006 SHALL have port flush_i, input, 1, synchronous kill of the in-flight or pending operation.
REQ-007 SHALL have port ex_func_i, input, ex_func, ALU operation code.
REQ-008 SHALL have port md_en_i / md_op_i, input, 1 / 3, M-extension select and op (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-009 SHALL have port rs1_sel_i / rs2_sel_i, input, rs1_sel / rs2_sel; operand A: 1 = rs1_data_i, 0 = pc_i; operand B: 1 = rs2_data_i, 0 = immediate_i.
REQ-010 SHALL have port pc_i, rs1_data_i, rs2_data_i, immediate_i, input, XLEN each, operands.
REQ-011 SHALL have port rd_i / ctrl_i, input, 5 / CTRL_W, destination register and control sideband.
REQ-012 SHALL have port out_valid_o / out_ready_i, output / input, 1 each, result handshake to the memory stage.
REQ-013 SHALL have port result_o, output, XLEN; zero_o, output, 1 (result_o == 0).
REQ-014 SHALL have port pc_o, pc_4_o, pc_imm_o, output, XLEN each; rd_o, output, 5; ctrl_o, output, CTRL_W; illegal_o, output, 1.

Function
REQ-015 SHALL accept an operation when in_valid_i && in_ready_o, capturing operands, rd_i, ctrl_i, pc_i, pc_i+4, pc_i+immediate_i (mod 2^XLEN).
REQ-016 SHALL implement FSM IDLE -> BUSY (md_en_i op accepted) -> DONE; IDLE -> DONE (ALU op accepted); DONE -> IDLE on out_ready_i with no new accept; DONE -> DONE/BUSY on out_ready_i with simultaneous accept.
REQ-017 SHALL assert in_ready_o in IDLE, and in DONE only when out_ready_i is high; never in BUSY.
REQ-018 SHALL present ALU results with out_valid_o high exactly one cycle after acceptance.
REQ-019 SHALL compute M-ops iteratively, one bit per cycle, out_valid_o rising exactly XLEN+1 cycles after acceptance, regardless of operand values.
REQ-020 SHALL hold all outputs stable while out_valid_o && !out_ready_i.
REQ-021 SHALL on divide-by-zero return all-ones quotient (DIV/DIVU) and the dividend as remainder (REM/REMU).
REQ-022 SHALL on signed overflow (-2^(XLEN-1) / -1) return quotient = dividend, remainder = 0.
REQ-023 SHALL return the low XLEN bits for MUL and the high XLEN bits of the 2*XLEN product for MULH/MULHSU/MULHU with RISC-V signedness.
REQ-024 SHALL, on flush_i, abort any BUSY operation, drop any DONE result, deassert out_valid_o and enter IDLE next cycle; flush_i has priority over a same-cycle accept, which is discarded.
REQ-025 SHALL keep out_valid_o low whenever state is IDLE or BUSY.

Reset
REQ-026 SHALL, while n_rst is low, force state IDLE and all registered outputs (result_o, pc_o, pc_4_o, pc_imm_o, rd_o, ctrl_o, illegal_o, out_valid_o) to 0; zero_o reads 1.
REQ-027 SHALL discard any in-flight M-op on reset assertion mid-operation; first accept possible the first edge after n_rst rises.

Configuration
REQ-028 SHALL compile the iterative multiply/divide datapath only when UCRV_MULDIV_EN is defined.
REQ-029 SHALL, without UCRV_MULDIV_EN, treat an accepted md_en_i op as illegal: one-cycle latency, result_o = 0, illegal_o = 1, BUSY unreachable; with it, illegal_o is always 0.

Verification
REQ-030 SHALL verify ALU ADD rs1=5, rs2=7, out_ready_i=1 -> out_valid_o next cycle, result_o=12, zero_o=0.
REQ-031 SHALL verify DIV 0x80000000 / 0xFFFFFFFF -> result_o=0x80000000 at cycle 33; REM same operands -> 0.
REQ-032 SHALL verify DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000, MULHU -> 0xFFFFFFFE.
REQ-033 SHALL verify out_ready_i held low 5 cycles after result -> outputs stable, in_ready_o=0, single transfer on release.
REQ-034 SHALL verify flush_i at cycle 10 of a MUL -> out_valid_o never rises, in_ready_o=1 next cycle; back-to-back ALU ops at out_ready_i=1 -> one result per cycle.
